// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity type encoding
// (common with the TX parity calculation) and the supported oversampling ratios.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int unsigned PRESCALE_X8  = 8;
   localparam int unsigned PRESCALE_X16 = 16;
   localparam int unsigned PRESCALE_X32 = 32;

   function automatic logic prescale_legal(input int unsigned p);
      return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and frame configuration in,
// received word, strobes and busy flag out.
interface uart_rx_if #(
   parameter int DATA       = 8,
   parameter int PRESCALE_W = 6
);

   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [PRESCALE_W-1:0] Prescale;
   logic [DATA-1:0]       P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;

   // System side: drives the line and configuration, observes results
   modport master (
      output RX_IN, PAR_EN, PAR_TYP, Prescale,
      input  P_DATA, data_valid, par_err, stp_err, busy
   );

   // Receiver side
   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP, Prescale,
      output P_DATA, data_valid, par_err, stp_err, busy
   );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: counts oversampling edges within a
// bit, takes a 3-point majority vote around mid-bit and flags the last edge.
module uart_rx_sampler #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  bit_done,
   output logic                  sampled_bit
);

   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] last_edge;
   logic [PRESCALE_W-1:0] mid_edge;
   logic [2:0]            samples;

   assign last_edge = prescale - PRESCALE_W'(1);
   assign mid_edge  = prescale >> 1;

   // Edge counter: idles at 0, wraps at P-1 so each bit starts from edge 0
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt <= '0;
      end else if (!run) begin
         edge_cnt <= '0;
      end else if (edge_cnt == last_edge) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
   end

   // Capture the line at the three edges centred on mid-bit
   always_ff @(posedge clk) begin
      if (rst) begin
         samples <= 3'b000;
      end else if (run) begin
         if (edge_cnt == mid_edge - PRESCALE_W'(1)) samples[0] <= rx_in;
         if (edge_cnt == mid_edge)                  samples[1] <= rx_in;
         if (edge_cnt == mid_edge + PRESCALE_W'(1)) samples[2] <= rx_in;
      end
   end

   assign bit_done    = run && (edge_cnt == last_edge);
   assign sampled_bit = (samples[0] & samples[1]) |
                        (samples[0] & samples[2]) |
                        (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start / DATA bits LSB first / optional parity /
// stop. Produces the received word with a one-cycle valid strobe, or a
// one-cycle parity and/or stop error strobe instead.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA       = 8,
   parameter int PRESCALE_W = 6
) (
   input logic      CLK,
   input logic      RST,
   uart_rx_if.slave bus
);

   localparam int BIT_W = (DATA > 1) ? $clog2(DATA) : 1;

   rx_state_t             state_q;
   rx_state_t             state_d;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA-1:0]       shift_q;
   logic [DATA-1:0]       p_data_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  par_bad_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [PRESCALE_W-1:0] prescale_new;
   logic [PRESCALE_W-1:0] prescale_eff;
   logic                  start_det;
   logic                  run;
   logic                  bit_done;
   logic                  sampled_bit;
   logic                  expected_par;
   logic                  data_valid_q;
   logic                  par_err_q;
   logic                  stp_err_q;

   assign start_det = (state_q == ST_IDLE) && !bus.RX_IN;
   assign run       = (state_q != ST_IDLE) || start_det;

   // An unsupported ratio falls back to x16 so a frame always terminates
   assign prescale_new = prescale_legal(int'(bus.Prescale)) ? bus.Prescale
                                                            : PRESCALE_W'(PRESCALE_X16);

   // The start-detect cycle is edge 0 of the start bit, before the latch updates
   assign prescale_eff = start_det ? prescale_new : prescale_q;

   assign expected_par = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

   uart_rx_sampler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .clk         (CLK),
      .rst         (RST),
      .run         (run),
      .rx_in       (bus.RX_IN),
      .prescale    (prescale_eff),
      .bit_done    (bit_done),
      .sampled_bit (sampled_bit)
   );

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: every transition after IDLE happens on the last edge of a bit
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!bus.RX_IN) state_d = ST_START;
         end
         ST_START: begin
            if (bit_done) state_d = sampled_bit ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (bit_done && (bit_cnt == BIT_W'(DATA - 1))) begin
               state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_done) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (bit_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: config latch, shift register, error capture and registered strobes
   always_ff @(posedge CLK) begin
      if (RST) begin
         bit_cnt      <= '0;
         shift_q      <= '0;
         p_data_q     <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_bad_q    <= 1'b0;
         prescale_q   <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_det) begin
                  par_en_q   <= bus.PAR_EN;
                  par_typ_q  <= bus.PAR_TYP;
                  prescale_q <= prescale_new;
                  bit_cnt    <= '0;
                  par_bad_q  <= 1'b0;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  shift_q[bit_cnt] <= sampled_bit;
                  if (bit_cnt == BIT_W'(DATA - 1)) begin
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (bit_done) par_bad_q <= (sampled_bit != expected_par);
            end
            ST_STOP: begin
               if (bit_done) begin
                  stp_err_q <= !sampled_bit;
                  par_err_q <= par_bad_q;
                  if (!par_bad_q && sampled_bit) begin
                     data_valid_q <= 1'b1;
                     p_data_q     <= shift_q;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.P_DATA     = p_data_q;
   assign bus.data_valid = data_valid_q;
   assign bus.par_err    = par_err_q;
   assign bus.stp_err    = stp_err_q;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: drives whole frames bit by bit, counts the
// output strobes on the falling edge and compares against hand-computed values.
module tb_uart_rx;
   import uart_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   int tests_run    = 0;
   int tests_failed = 0;

   int          dv_cnt       = 0;
   int          pe_cnt       = 0;
   int          se_cnt       = 0;
   int          dv_cyc       = 0;
   int          prev_dv_cyc  = 0;
   logic [7:0]  dv_data      = 8'h00;
   logic [7:0]  prev_dv_data = 8'h00;

   uart_rx_if #(.DATA(8), .PRESCALE_W(6)) bus ();

   uart_rx #(
      .DATA       (8),
      .PRESCALE_W (6)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // 100 MHz oversampling clock
   always #5 clk = ~clk;

   // Cycle counter used to time strobes relative to start detection
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.data_valid) begin
         dv_cnt       <= dv_cnt + 1;
         prev_dv_cyc  <= dv_cyc;
         dv_cyc       <= cyc;
         prev_dv_data <= dv_data;
         dv_data      <= bus.P_DATA;
      end
      if (bus.par_err) pe_cnt <= pe_cnt + 1;
      if (bus.stp_err) se_cnt <= se_cnt + 1;
   end

   // Hard stop in case the stimulus ever stalls
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic driveBit(input logic b, input int n);
      bus.RX_IN = b;
      repeat (n) tick();
   endtask

   // Sends one frame; start_cyc is the cycle in which the start bit is detected
   task automatic applyStimulus(input logic [7:0] data, input int p,
                                input logic par_en, input logic par_typ,
                                input logic par_bit, input logic stop_bit,
                                output int start_cyc);
      bus.Prescale = 6'(p);
      bus.PAR_EN   = par_en;
      bus.PAR_TYP  = par_typ;
      start_cyc    = cyc;
      driveBit(1'b0, p);
      checkOutput("busy_in_frame", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 8; i++) driveBit(data[i], p);
      if (par_en) driveBit(par_bit, p);
      driveBit(stop_bit, p);
   endtask

   initial begin
      int s, s2;
      int dv0, pe0, se0;

      rst          = 1'b1;
      bus.RX_IN    = 1'b1;
      bus.PAR_EN   = 1'b0;
      bus.PAR_TYP  = PAR_EVEN;
      bus.Prescale = 6'd8;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      $display("[TB] reset state");
      checkOutput("rst_p_data",     32'(bus.P_DATA),     32'h00);
      checkOutput("rst_data_valid", 32'(bus.data_valid), 32'd0);
      checkOutput("rst_par_err",    32'(bus.par_err),    32'd0);
      checkOutput("rst_stp_err",    32'(bus.stp_err),    32'd0);
      checkOutput("rst_busy",       32'(bus.busy),       32'd0);

      $display("[TB] x8 even parity, 0xA5");
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      applyStimulus(8'hA5, 8, 1'b1, PAR_EVEN, 1'b0, 1'b1, s);
      checkOutput("t1_busy_done", 32'(bus.busy), 32'd0);
      driveBit(1'b1, 4);
      checkOutput("t1_dv_count", 32'(dv_cnt - dv0), 32'd1);
      checkOutput("t1_latency",  32'(dv_cyc - s),   32'd88);
      checkOutput("t1_p_data",   32'(bus.P_DATA),   32'hA5);
      checkOutput("t1_par_err",  32'(pe_cnt - pe0), 32'd0);
      checkOutput("t1_stp_err",  32'(se_cnt - se0), 32'd0);

      $display("[TB] x8 odd parity, 0x3C with wrong parity bit");
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      applyStimulus(8'h3C, 8, 1'b1, PAR_ODD, 1'b0, 1'b1, s);
      driveBit(1'b1, 4);
      checkOutput("t2_par_err",  32'(pe_cnt - pe0), 32'd1);
      checkOutput("t2_dv_count", 32'(dv_cnt - dv0), 32'd0);
      checkOutput("t2_stp_err",  32'(se_cnt - se0), 32'd0);
      checkOutput("t2_p_data",   32'(bus.P_DATA),   32'hA5);

      $display("[TB] x16 no parity, 0x81 with bad stop, then 0x7E");
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      applyStimulus(8'h81, 16, 1'b0, PAR_EVEN, 1'b0, 1'b0, s);
      driveBit(1'b1, 4);
      checkOutput("t3_stp_err",  32'(se_cnt - se0), 32'd1);
      checkOutput("t3_dv_count", 32'(dv_cnt - dv0), 32'd0);
      checkOutput("t3_p_data",   32'(bus.P_DATA),   32'hA5);
      applyStimulus(8'h7E, 16, 1'b0, PAR_EVEN, 1'b0, 1'b1, s);
      driveBit(1'b1, 4);
      checkOutput("t3b_dv_count", 32'(dv_cnt - dv0), 32'd1);
      checkOutput("t3b_latency",  32'(dv_cyc - s),   32'd160);
      checkOutput("t3b_p_data",   32'(bus.P_DATA),   32'h7E);

      $display("[TB] x16 two-cycle glitch");
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      bus.Prescale = 6'd16;
      bus.RX_IN    = 1'b0;
      tick();
      tick();
      bus.RX_IN = 1'b1;
      repeat (13) tick();
      checkOutput("t4_busy_edge15", 32'(bus.busy), 32'd1);
      tick();
      checkOutput("t4_busy_after", 32'(bus.busy), 32'd0);
      driveBit(1'b1, 20);
      checkOutput("t4_no_strobes", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

      $display("[TB] x32 back-to-back 0x01, 0xFE");
      dv0 = dv_cnt;
      applyStimulus(8'h01, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, s);
      applyStimulus(8'hFE, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, s2);
      driveBit(1'b1, 4);
      checkOutput("t5_dv_count",   32'(dv_cnt - dv0),        32'd2);
      checkOutput("t5_gap",        32'(dv_cyc - prev_dv_cyc), 32'd320);
      checkOutput("t5_first_data", 32'(prev_dv_data),        32'h01);
      checkOutput("t5_last_data",  32'(dv_data),             32'hFE);
      checkOutput("t5_latency",    32'(dv_cyc - s2),         32'd320);

      $display("[TB] x8 reset during data bit 3, then clean 0x5A");
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      bus.Prescale = 6'd8;
      bus.PAR_EN   = 1'b0;
      driveBit(1'b0, 8);
      driveBit(1'b0, 8);
      driveBit(1'b1, 8);
      driveBit(1'b0, 8);
      bus.RX_IN = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t6_busy_reset", 32'(bus.busy), 32'd0);
      driveBit(1'b1, 100);
      checkOutput("t6_no_strobes", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
      applyStimulus(8'h5A, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, s);
      driveBit(1'b1, 4);
      checkOutput("t6_dv_count", 32'(dv_cnt - dv0), 32'd1);
      checkOutput("t6_latency",  32'(dv_cyc - s),   32'd80);
      checkOutput("t6_p_data",   32'(bus.P_DATA),   32'h5A);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
